// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Byte-serial memory controller. Arbitrates instruction fetch (IF)
//            and load/store (MEM) requests onto one 8-bit registered RAM port,
//            splitting 1/2/4-byte requests into sequential byte accesses and
//            returning a one-cycle done pulse to the requester.
// Ports    : clk_in, rst_in (async, active-high), rdy_in (global freeze)
//            if_req_in / if_addr_in / if_flush_in -> if_data_out / if_done_out
//            mem_req_in / mem_we_in / mem_len_in / mem_addr_in / mem_wdata_in
//                                           -> mem_rdata_out / mem_done_out
//            ram_din (registered RAM read data), ram_dout, ram_a, ram_wr
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  input  logic              if_flush_in,
  output logic [31:0]       if_data_out,
  output logic              if_done_out,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [2:0]        mem_len_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [31:0]       mem_wdata_in,
  output logic [31:0]       mem_rdata_out,
  output logic              mem_done_out,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t            state;
  logic              owner_mem;   // 1 = MEM owns the transaction, 0 = IF
  logic [ADDR_W-1:0] base;
  logic [2:0]        len;
  logic [2:0]        iss;         // bytes whose address has been put on ram_a
  logic [2:0]        rcv;         // bytes captured into the buffer
  logic [31:0]       buffer;      // read assembly / store data
  logic              addr_valid;  // ram_a holds an address of this read
  logic              rd_valid;    // ram_din holds the byte for index rcv
  logic [7:0]        skid_byte;
  logic              skid_valid;

  logic [2:0]        req_len;
  logic [7:0]        din_eff;
  logic [31:0]       merged;
  logic [7:0]        wbyte;
  logic [ADDR_W-1:0] next_addr;
  logic              last_byte;

  // Lengths other than 1 or 2 are handled as a full word.
  always_comb begin
    case (mem_len_in)
      3'd1:    req_len = 3'd1;
      3'd2:    req_len = 3'd2;
      default: req_len = 3'd4;
    endcase
  end

  // The RAM keeps running while rdy_in is low, so ram_din moves on to the
  // byte of the held address. The byte that was due is parked in the skid
  // register on the first frozen edge and consumed on the resume edge.
  assign din_eff = skid_valid ? skid_byte : ram_din;

  always_comb begin
    merged = buffer;
    case (rcv[1:0])
      2'd0:    merged[7:0]   = din_eff;
      2'd1:    merged[15:8]  = din_eff;
      2'd2:    merged[23:16] = din_eff;
      default: merged[31:24] = din_eff;
    endcase
  end

  always_comb begin
    case (iss[1:0])
      2'd0:    wbyte = buffer[7:0];
      2'd1:    wbyte = buffer[15:8];
      2'd2:    wbyte = buffer[23:16];
      default: wbyte = buffer[31:24];
    endcase
  end

  assign next_addr = base + ADDR_W'(iss);
  assign last_byte = ((rcv + 3'd1) == len);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      owner_mem     <= 1'b0;
      base          <= '0;
      len           <= 3'd0;
      iss           <= 3'd0;
      rcv           <= 3'd0;
      buffer        <= 32'd0;
      addr_valid    <= 1'b0;
      rd_valid      <= 1'b0;
      skid_byte     <= 8'd0;
      skid_valid    <= 1'b0;
      ram_a         <= '0;
      ram_dout      <= 8'd0;
      ram_wr        <= 1'b0;
      if_data_out   <= 32'd0;
      if_done_out   <= 1'b0;
      mem_rdata_out <= 32'd0;
      mem_done_out  <= 1'b0;
    end else if (!rdy_in) begin
      if (!skid_valid) begin
        skid_byte  <= ram_din;
        skid_valid <= 1'b1;
      end
    end else begin
      skid_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (if_done_out || mem_done_out) begin
            // Done cycle ends here; no accept on this edge gives the bubble.
            if_done_out  <= 1'b0;
            mem_done_out <= 1'b0;
          end else if (mem_req_in) begin
            owner_mem  <= 1'b1;
            base       <= mem_addr_in;
            len        <= req_len;
            ram_a      <= mem_addr_in;
            iss        <= 3'd1;
            rcv        <= 3'd0;
            rd_valid   <= 1'b0;
            if (mem_we_in) begin
              buffer     <= mem_wdata_in;
              ram_dout   <= mem_wdata_in[7:0];
              ram_wr     <= 1'b1;
              addr_valid <= 1'b0;
              state      <= WRITE;
            end else begin
              buffer     <= 32'd0;
              addr_valid <= 1'b1;
              state      <= READ;
            end
          end else if (if_req_in) begin
            owner_mem  <= 1'b0;
            base       <= if_addr_in;
            len        <= 3'd4;
            ram_a      <= if_addr_in;
            iss        <= 3'd1;
            rcv        <= 3'd0;
            buffer     <= 32'd0;
            addr_valid <= 1'b1;
            rd_valid   <= 1'b0;
            state      <= READ;
          end
        end

        READ: begin
          if (if_flush_in && !owner_mem) begin
            addr_valid <= 1'b0;
            rd_valid   <= 1'b0;
            state      <= IDLE;
          end else begin
            // The registered RAM returns a byte one edge after its address
            // is sampled, so capture trails issue by one pipeline stage.
            rd_valid <= addr_valid;
            if (iss < len) begin
              ram_a <= next_addr;
              iss   <= iss + 3'd1;
            end else begin
              addr_valid <= 1'b0;
            end
            if (rd_valid) begin
              buffer <= merged;
              rcv    <= rcv + 3'd1;
              if (last_byte) begin
                if (owner_mem) begin
                  mem_rdata_out <= merged;
                  mem_done_out  <= 1'b1;
                end else begin
                  if_data_out <= merged;
                  if_done_out <= 1'b1;
                end
                addr_valid <= 1'b0;
                rd_valid   <= 1'b0;
                state      <= IDLE;
              end
            end
          end
        end

        WRITE: begin
          if (iss < len) begin
            ram_a    <= next_addr;
            ram_dout <= wbyte;
            iss      <= iss + 3'd1;
          end else begin
            ram_wr       <= 1'b0;
            mem_done_out <= 1'b1;
            state        <= IDLE;
          end
        end

        default: begin
          ram_wr <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Directed self-checking bench for mem_ctrl with a registered
//            byte-wide RAM model (64 KiB window on ram_a[15:0]).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic        if_flush_in;
  logic [31:0] if_data_out;
  logic        if_done_out;
  logic        mem_req_in;
  logic        mem_we_in;
  logic [2:0]  mem_len_in;
  logic [31:0] mem_addr_in;
  logic [31:0] mem_wdata_in;
  logic [31:0] mem_rdata_out;
  logic        mem_done_out;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cycles = 0;

  logic [7:0] rom   [0:65535];
  logic [7:0] wmem  [0:65535];
  bit         wvalid[0:65535];

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .if_req_in     (if_req_in),
    .if_addr_in    (if_addr_in),
    .if_flush_in   (if_flush_in),
    .if_data_out   (if_data_out),
    .if_done_out   (if_done_out),
    .mem_req_in    (mem_req_in),
    .mem_we_in     (mem_we_in),
    .mem_len_in    (mem_len_in),
    .mem_addr_in   (mem_addr_in),
    .mem_wdata_in  (mem_wdata_in),
    .mem_rdata_out (mem_rdata_out),
    .mem_done_out  (mem_done_out),
    .ram_din       (ram_din),
    .ram_dout      (ram_dout),
    .ram_a         (ram_a),
    .ram_wr        (ram_wr)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] rd(input logic [15:0] a);
    return wvalid[a] ? wmem[a] : rom[a];
  endfunction

  // Registered RAM: address sampled at the edge, data visible after it.
  always @(posedge clk_in) begin
    ram_din <= rd(ram_a[15:0]);
    if (ram_wr) begin
      wmem[ram_a[15:0]]   <= ram_dout;
      wvalid[ram_a[15:0]] <= 1'b1;
      wr_cycles           <= wr_cycles + 1;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Ticks until the selected done output is high; cyc = ticks taken.
  task automatic wait_done(input bit for_mem, input int limit, output int cyc);
    cyc = 0;
    while (((for_mem ? mem_done_out : if_done_out) !== 1'b1) && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int w0;
    int hits;

    for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
    rom[16'h1000] = 8'h13; rom[16'h1001] = 8'h05; rom[16'h1002] = 8'h00; rom[16'h1003] = 8'h00;
    rom[16'h1004] = 8'h93; rom[16'h1005] = 8'h00; rom[16'h1006] = 8'h10; rom[16'h1007] = 8'h00;
    rom[16'h1008] = 8'h37; rom[16'h1009] = 8'h01; rom[16'h100A] = 8'h02; rom[16'h100B] = 8'h00;
    rom[16'h2000] = 8'h11; rom[16'h2001] = 8'h22; rom[16'h2002] = 8'h33; rom[16'h2003] = 8'h44;
    rom[16'h0040] = 8'h80; rom[16'h0041] = 8'hFF;
    rom[16'h0050] = 8'h01; rom[16'h0051] = 8'h02; rom[16'h0052] = 8'h03; rom[16'h0053] = 8'h04;
    rom[16'hFFFE] = 8'hAA; rom[16'hFFFF] = 8'hBB; rom[16'h0000] = 8'hCC; rom[16'h0001] = 8'hDD;

    rst_in = 1'b1; rdy_in = 1'b1;
    if_req_in = 1'b0; if_addr_in = 32'd0; if_flush_in = 1'b0;
    mem_req_in = 1'b0; mem_we_in = 1'b0; mem_len_in = 3'd4;
    mem_addr_in = 32'd0; mem_wdata_in = 32'd0;

    // Reset state
    tick(); tick();
    check("rst_ram_a",    ram_a,         32'd0);
    check("rst_ram_wr",   {31'd0, ram_wr}, 32'd0);
    check("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    check("rst_if_done",  {31'd0, if_done_out}, 32'd0);
    check("rst_mem_done", {31'd0, mem_done_out}, 32'd0);
    check("rst_if_data",  if_data_out,   32'd0);
    check("rst_mem_data", mem_rdata_out, 32'd0);
    rst_in = 1'b0;
    tick();

    // 4-byte fetch at 0x1000
    w0 = wr_cycles;
    if_req_in = 1'b1; if_addr_in = 32'h1000;
    tick();
    check("if_ram_a0", ram_a, 32'h1000);
    wait_done(1'b0, 20, cyc);
    check("if_latency", cyc, 32'd5);
    check("if_data", if_data_out, 32'h0000_0513);
    if_req_in = 1'b0;
    tick();
    check("if_done_pulse", {31'd0, if_done_out}, 32'd0);
    check("if_no_write", wr_cycles - w0, 32'd0);

    // Simultaneous IF and MEM: MEM first, IF after done + one bubble
    if_req_in = 1'b1; if_addr_in = 32'h1004;
    mem_req_in = 1'b1; mem_we_in = 1'b0; mem_len_in = 3'd4; mem_addr_in = 32'h2000;
    tick();
    check("arb_ram_a0", ram_a, 32'h2000);
    wait_done(1'b1, 20, cyc);
    check("arb_mem_latency", cyc, 32'd5);
    check("arb_if_not_done", {31'd0, if_done_out}, 32'd0);
    check("arb_mem_data", mem_rdata_out, 32'h4433_2211);
    mem_req_in = 1'b0;
    wait_done(1'b0, 20, cyc);
    check("arb_if_latency", cyc, 32'd7);
    check("arb_if_data", if_data_out, 32'h0010_0093);
    if_req_in = 1'b0;
    tick();

    // 2-byte store
    w0 = wr_cycles;
    mem_req_in = 1'b1; mem_we_in = 1'b1; mem_len_in = 3'd2;
    mem_addr_in = 32'h30; mem_wdata_in = 32'hAABB_CCDD;
    tick();
    check("st_wr0",   {31'd0, ram_wr}, 32'd1);
    check("st_a0",    ram_a, 32'h30);
    check("st_d0",    {24'd0, ram_dout}, 32'hDD);
    tick();
    check("st_wr1",   {31'd0, ram_wr}, 32'd1);
    check("st_a1",    ram_a, 32'h31);
    check("st_d1",    {24'd0, ram_dout}, 32'hCC);
    check("st_early_done", {31'd0, mem_done_out}, 32'd0);
    tick();
    check("st_wr_off", {31'd0, ram_wr}, 32'd0);
    check("st_done",   {31'd0, mem_done_out}, 32'd1);
    mem_req_in = 1'b0; mem_we_in = 1'b0;
    tick();
    check("st_done_pulse", {31'd0, mem_done_out}, 32'd0);
    check("st_wr_count", wr_cycles - w0, 32'd2);
    check("st_mem30", {24'd0, rd(16'h30)}, 32'hDD);
    check("st_mem31", {24'd0, rd(16'h31)}, 32'hCC);
    check("st_mem32", {24'd0, rd(16'h32)}, 32'h00);

    // 1-byte load, zero-extended
    mem_req_in = 1'b1; mem_len_in = 3'd1; mem_addr_in = 32'h40;
    tick();
    wait_done(1'b1, 20, cyc);
    check("lb_latency", cyc, 32'd2);
    check("lb_data", mem_rdata_out, 32'h0000_0080);
    mem_req_in = 1'b0;
    tick();

    // len=3 behaves as 4
    mem_req_in = 1'b1; mem_len_in = 3'd3; mem_addr_in = 32'h50;
    tick();
    wait_done(1'b1, 20, cyc);
    check("len3_latency", cyc, 32'd5);
    check("len3_data", mem_rdata_out, 32'h0403_0201);
    mem_req_in = 1'b0;
    tick();

    // Address wrap at 0xFFFFFFFF
    mem_req_in = 1'b1; mem_len_in = 3'd4; mem_addr_in = 32'hFFFF_FFFE;
    tick();
    wait_done(1'b1, 20, cyc);
    check("wrap_latency", cyc, 32'd5);
    check("wrap_data", mem_rdata_out, 32'hDDCC_BBAA);
    mem_req_in = 1'b0;
    tick();

    // Flush two cycles into a fetch
    if_req_in = 1'b1; if_addr_in = 32'h1000;
    tick(); tick(); tick();
    if_flush_in = 1'b1; if_req_in = 1'b0;
    tick();
    if_flush_in = 1'b0;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      if (if_done_out) hits++;
      tick();
    end
    check("flush_no_done", hits, 32'd0);
    check("flush_data_kept", if_data_out, 32'h0010_0093);
    if_req_in = 1'b1; if_addr_in = 32'h1008;
    tick();
    wait_done(1'b0, 20, cyc);
    check("post_flush_latency", cyc, 32'd5);
    check("post_flush_data", if_data_out, 32'h0002_0137);
    if_req_in = 1'b0;
    tick();

    // rdy_in low for 3 cycles mid-read
    mem_req_in = 1'b1; mem_we_in = 1'b0; mem_len_in = 3'd4; mem_addr_in = 32'h2000;
    tick(); tick(); tick();
    rdy_in = 1'b0;
    repeat (3) tick();
    rdy_in = 1'b1;
    wait_done(1'b1, 20, cyc);
    check("stall_latency", cyc, 32'd3);
    check("stall_data", mem_rdata_out, 32'h4433_2211);
    rdy_in = 1'b0;
    tick(); tick();
    check("done_stretch", {31'd0, mem_done_out}, 32'd1);
    mem_req_in = 1'b0; rdy_in = 1'b1;
    tick();
    check("done_after_stretch", {31'd0, mem_done_out}, 32'd0);

    // Asynchronous reset in the middle of a 4-byte store
    w0 = wr_cycles;
    mem_req_in = 1'b1; mem_we_in = 1'b1; mem_len_in = 3'd4;
    mem_addr_in = 32'h60; mem_wdata_in = 32'h1122_3344;
    tick(); tick();
    check("rst_wr_before", {31'd0, ram_wr}, 32'd1);
    rst_in = 1'b1;
    #1;
    check("rst_wr_async",   {31'd0, ram_wr}, 32'd0);
    check("rst_a_async",    ram_a, 32'd0);
    check("rst_mdone_async", {31'd0, mem_done_out}, 32'd0);
    check("rst_idone_async", {31'd0, if_done_out}, 32'd0);
    check("rst_mdata_async", mem_rdata_out, 32'd0);
    mem_req_in = 1'b0; mem_we_in = 1'b0;
    tick();
    rst_in = 1'b0;
    tick();
    check("rst_wr_count", wr_cycles - w0, 32'd1);
    check("rst_mem60", {24'd0, rd(16'h60)}, 32'h44);
    check("rst_mem61", {24'd0, rd(16'h61)}, 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
